sigmoid_relu_all: RTL and testbench

//  Per-neuron activation unit for the DNN datapath: for one signed fixed-point input, produces

---
 rtl/sigmoid_relu_all.sv | 151 +++++++++++++++
 tb/tb_sigmoid_relu_all.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_relu_all.sv
`timescale 1ns/1ps
// sigmoid_relu_all
//   Per-neuron activation unit. For one signed fixed-point pre-activation it
//   produces sigmoid, sigmoid derivative, ReLU and ReLU derivative, all
//   registered together (1-cycle latency, new input accepted every cycle,
//   no handshake).
//
//   Sigmoid values come from a ROM indexed by |val| holding sigma(x) and
//   sigma(x)*(1-sigma(x)) for x >= 0, scaled by S = 2^frac_bits and rounded
//   to nearest. The ROM contents are computed at elaboration time by constant
//   functions using integer fixed-point arithmetic (Q24). Negative inputs
//   reuse the table by symmetry: sigma(-x) = 1 - sigma(x), sigma'(-x) = sigma'(x).
//
//   Optional feature macro: ACT_LEAKY_RELU_EN
//     defined   -> leaky ReLU for val < 0 (relu = val>>>3, relu' = S>>3)
//     undefined -> plain ReLU
//
// Ports
//   clk               in   rising-edge clock
//   reset_n           in   asynchronous active-low reset, clears all outputs
//   val               in   [width-1:0] signed fixed-point input
//   sigmoid_out       out  [width-1:0] round(S*sigma(x))
//   sigmoid_prime_out out  [width-1:0] round(S*sigma(x)*(1-sigma(x)))
//   relu_out          out  [width-1:0] max(0, val) (or leaky variant)
//   relu_prime_out    out  [width-1:0] S if val > 0 else 0 (or S>>3 leaky)
module sigmoid_relu_all #(
  parameter int width     = 12,
  parameter int frac_bits = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [width-1:0] val,
  output logic [width-1:0] sigmoid_out,
  output logic [width-1:0] sigmoid_prime_out,
  output logic [width-1:0] relu_out,
  output logic [width-1:0] relu_prime_out
);

  localparam int               depth  = 2 ** (width - 1);
  localparam int               q_bits = 24;
  localparam longint           q_one  = longint'(1) <<< q_bits;
  localparam logic [width-1:0] s_val  = width'(1 << frac_bits);

  // e^(mag/S) in Q24 via Taylor series; all terms are positive so the
  // truncation error stays far below one output LSB over [0, 4).
  function automatic longint exp_q(input int mag);
    longint term;
    longint sum;
    term = q_one;
    sum  = q_one;
    for (int n = 1; n <= 40; n++) begin
      term = (term * longint'(mag)) / (longint'(n) <<< frac_bits);
      sum  = sum + term;
    end
    return sum;
  endfunction

  // sigma(mag/S) = e/(1+e) in Q24
  function automatic longint sigma_q(input int mag);
    longint e;
    e = exp_q(mag);
    return (e * q_one) / (q_one + e);
  endfunction

  // Values are non-negative, so adding half an LSB then truncating gives
  // round-to-nearest with ties away from zero.
  function automatic logic [width-1:0] rom_sigma_val(input int mag);
    longint p;
    longint r;
    p = sigma_q(mag);
    r = ((p <<< (frac_bits + 1)) + q_one) >>> (q_bits + 1);
    return width'(r);
  endfunction

  function automatic logic [width-1:0] rom_prime_val(input int mag);
    longint p;
    longint r;
    p = sigma_q(mag);
    r = (((p * (q_one - p)) <<< (frac_bits + 1)) + (q_one * q_one)) >>> (2 * q_bits + 1);
    return width'(r);
  endfunction

  logic [width-1:0] rom_sigma [depth];
  logic [width-1:0] rom_prime [depth];

  for (genvar i = 0; i < depth; i++) begin : g_rom
    localparam logic [width-1:0] sig_c   = rom_sigma_val(i);
    localparam logic [width-1:0] prime_c = rom_prime_val(i);
    assign rom_sigma[i] = sig_c;
    assign rom_prime[i] = prime_c;
  end

  logic             neg;
  logic [width-2:0] mag;
  logic [width-1:0] sig_rom;
  logic [width-1:0] prime_rom;
  logic [width-1:0] sigmoid_d, sigmoid_q;
  logic [width-1:0] sigmoid_prime_d, sigmoid_prime_q;
  logic [width-1:0] relu_d, relu_q;
  logic [width-1:0] relu_prime_d, relu_prime_q;

  always_comb begin
    neg = val[width-1];
    mag = val[width-2:0];
    if (neg) begin
      // The most-negative code has no positive counterpart: saturate |val|.
      if (val[width-2:0] == '0) mag = '1;
      else                      mag = -val[width-2:0];
    end

    sig_rom   = rom_sigma[mag];
    prime_rom = rom_prime[mag];

    sigmoid_d       = neg ? (s_val - sig_rom) : sig_rom;
    sigmoid_prime_d = prime_rom;

    relu_d       = '0;
    relu_prime_d = '0;
    if (!neg && (val != '0)) begin
      relu_d       = val;
      relu_prime_d = s_val;
    end
`ifdef ACT_LEAKY_RELU_EN
    else if (neg) begin
      relu_d       = $signed(val) >>> 3;
      relu_prime_d = s_val >> 3;
    end
`else
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sigmoid_q       <= '0;
      sigmoid_prime_q <= '0;
      relu_q          <= '0;
      relu_prime_q    <= '0;
    end else begin
      sigmoid_q       <= sigmoid_d;
      sigmoid_prime_q <= sigmoid_prime_d;
      relu_q          <= relu_d;
      relu_prime_q    <= relu_prime_d;
    end
  end

  assign sigmoid_out       = sigmoid_q;
  assign sigmoid_prime_out = sigmoid_prime_q;
  assign relu_out          = relu_q;
  assign relu_prime_out    = relu_prime_q;

endmodule

// File: tb/tb_sigmoid_relu_all.sv
`timescale 1ns/1ps
// Bench for sigmoid_relu_all: reset checks, directed vector table, hold and
// asynchronous-reset sequences, full code sweep and random stream compared
// against a real-valued sigmoid / ReLU model.
module tb_sigmoid_relu_all;

  localparam int W = 12;

`ifdef ACT_LEAKY_RELU_EN
  localparam bit leaky = 1'b1;
`else
  localparam bit leaky = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] v;
    logic [W-1:0] sig;
    logic [W-1:0] pr;
    logic [W-1:0] relu;
    logic [W-1:0] relup;
  } vec_t;

  // clock / reset
  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] val;
  logic [W-1:0] sigmoid_out;
  logic [W-1:0] sigmoid_prime_out;
  logic [W-1:0] relu_out;
  logic [W-1:0] relu_prime_out;

  always #5 clk = ~clk;

  sigmoid_relu_all #(.width(W), .frac_bits(9)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .val               (val),
    .sigmoid_out       (sigmoid_out),
    .sigmoid_prime_out (sigmoid_prime_out),
    .relu_out          (relu_out),
    .relu_prime_out    (relu_prime_out)
  );

  // scoreboard
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  vec_t         tbl[10];

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp, input logic [W-1:0] alt);
    n_cmp++;
    if (act !== exp && act !== alt) begin
      n_err++;
      $display("FAIL %s: got 0x%03h want 0x%03h (alt 0x%03h)", name, act, exp, alt);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t e);
    check($sformatf("%s_sig[%03h]", tag, e.v),   sigmoid_out,       e.sig,   e.sig);
    check($sformatf("%s_prime[%03h]", tag, e.v), sigmoid_prime_out, e.pr,    e.pr);
    check($sformatf("%s_relu[%03h]", tag, e.v),  relu_out,          e.relu,  e.relu);
    check($sformatf("%s_relup[%03h]", tag, e.v), relu_prime_out,    e.relup, e.relup);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sig"},   sigmoid_out,       '0, '0);
    check({tag, "_prime"}, sigmoid_prime_out, '0, '0);
    check({tag, "_relu"},  relu_out,          '0, '0);
    check({tag, "_relup"}, relu_prime_out,    '0, '0);
  endtask

  // Real-valued reference. Near an exact half-LSB either neighbour is accepted,
  // since a finite-precision table may land on either side of the tie.
  task automatic model_check(input logic [W-1:0] v);
    int           sv;
    int           iv;
    int           fs;
    int           fp;
    real          x;
    real          s;
    real          ys;
    real          yp;
    logic [W-1:0] es, as_, ep, ap, er, erp;
    sv = int'($signed(v));
    iv = (sv == -2048) ? -2047 : sv;
    x  = real'(iv) / 512.0;
    s  = 1.0 / (1.0 + $exp(-x));
    ys = 512.0 * s;
    yp = ys * (1.0 - s);
    fs = int'($floor(ys));
    fp = int'($floor(yp));
    es  = W'(int'($floor(ys + 0.5)));
    as_ = es;
    if ((ys - fs) > 0.49 && (ys - fs) < 0.51) begin
      es  = W'(fs);
      as_ = W'(fs + 1);
    end
    ep = W'(int'($floor(yp + 0.5)));
    ap = ep;
    if ((yp - fp) > 0.49 && (yp - fp) < 0.51) begin
      ep = W'(fp);
      ap = W'(fp + 1);
    end
    er  = '0;
    erp = '0;
    if (sv > 0) begin
      er  = v;
      erp = 12'h200;
    end else if (sv < 0 && leaky) begin
      er  = W'(-((-sv + 7) / 8));   // floor(val/8)
      erp = 12'h040;
    end
    check($sformatf("m_sig[%03h]", v),   sigmoid_out,       es,  as_);
    check($sformatf("m_prime[%03h]", v), sigmoid_prime_out, ep,  ap);
    check($sformatf("m_relu[%03h]", v),  relu_out,          er,  er);
    check($sformatf("m_relup[%03h]", v), relu_prime_out,    erp, erp);
  endtask

  // driver: one new value per edge, result checked against the value
  // sampled on the previous edge
  task automatic stream_check(input logic [W-1:0] v);
    logic [W-1:0] ev;
    val = v;
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    ev = exp_q.pop_front();
    model_check(ev);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{12'h804, 12'h009, 12'h009, leaky ? 12'hF00 : 12'h000, leaky ? 12'h040 : 12'h000};
    tbl[1] = '{12'h7FB, 12'h1F7, 12'h009, 12'h7FB, 12'h200};
    tbl[2] = '{12'h958, 12'h012, 12'h011, leaky ? 12'hF2B : 12'h000, leaky ? 12'h040 : 12'h000};
    tbl[3] = '{12'h000, 12'h100, 12'h080, 12'h000, 12'h000};
    tbl[4] = '{12'h800, 12'h009, 12'h009, leaky ? 12'hF00 : 12'h000, leaky ? 12'h040 : 12'h000};
    tbl[5] = '{12'h801, 12'h009, 12'h009, leaky ? 12'hF00 : 12'h000, leaky ? 12'h040 : 12'h000};
    tbl[6] = '{12'h001, 12'h100, 12'h080, 12'h001, 12'h200};
    tbl[7] = '{12'h200, 12'h176, 12'h065, 12'h200, 12'h200};
    tbl[8] = '{12'hE00, 12'h08A, 12'h065, leaky ? 12'hFC0 : 12'h000, leaky ? 12'h040 : 12'h000};
    tbl[9] = '{12'hFFF, 12'h100, 12'h080, leaky ? 12'hFFF : 12'h000, leaky ? 12'h040 : 12'h000};

    reset_n = 1'b0;
    val     = 12'h7FB;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst");

    @(negedge clk);
    reset_n = 1'b1;
    val     = 12'h000;
    @(posedge clk);

    // directed table
    foreach (tbl[i]) begin
      @(negedge clk);
      val = tbl[i].v;
      @(posedge clk);
      @(negedge clk);
      check_vec("tbl", tbl[i]);
    end

    // input change between edges is ignored until the next edge
    val = 12'h200;
    @(posedge clk);
    #1 val = 12'hE00;
    @(negedge clk);
    check_vec("hold", tbl[7]);
    @(posedge clk);
    @(negedge clk);
    check_vec("hold", tbl[8]);

    // asynchronous reset mid-run clears outputs before the next edge
    val = 12'h7FB;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero("arst");
    @(negedge clk);
    check_zero("arst_hold");
    reset_n = 1'b1;
    val     = 12'h200;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_vec("post_rst", tbl[7]);

    // ramp over every code
    for (int c = 0; c < 4096; c++) stream_check(W'(c));

    // random stream
    for (int k = 0; k < 400; k++) stream_check(W'($urandom_range(0, 4095)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
